// File: rtl/pressure_sequencer_pkg.sv
// Shared constants and state encoding for the chamber pressure sequencer.
package pressure_sequencer_pkg;

    localparam int PRESSURE_W = 14;
    localparam int P_LOW_DEF  = 13;
    localparam int P_HIGH_DEF = 16000;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        RAMP_UP   = 2'b01,
        IDLE_HIGH = 2'b10,
        RAMP_DOWN = 2'b11
    } seq_state_t;

endpackage

// File: rtl/pressure_step.sv
// Combinational saturating step of the pressure value toward P_HIGH (dir=1) or P_LOW (dir=0).
module pressure_step
    import pressure_sequencer_pkg::*;
#(
    parameter int P_LOW  = P_LOW_DEF,
    parameter int P_HIGH = P_HIGH_DEF,
    parameter int STEP   = 1000
) (
    input  logic [PRESSURE_W-1:0] value,
    input  logic                  dir,
    output logic [PRESSURE_W-1:0] next
);

    localparam logic [PRESSURE_W-1:0] LP_LOW   = PRESSURE_W'(P_LOW);
    localparam logic [PRESSURE_W-1:0] LP_HIGH  = PRESSURE_W'(P_HIGH);
    localparam logic [PRESSURE_W:0]   LP_HIGHW = (PRESSURE_W+1)'(P_HIGH);
    localparam logic [PRESSURE_W:0]   LP_STEPW = (PRESSURE_W+1)'(STEP);

    logic [PRESSURE_W:0] w_sum;
    logic [PRESSURE_W:0] w_diff;
    logic                w_borrow;

    assign w_sum    = {1'b0, value} + LP_STEPW;
    assign w_diff   = {1'b0, value} - LP_STEPW;
    assign w_borrow = ({1'b0, value} < LP_STEPW);

    always_comb begin
        next = value;
        if (dir) begin
            next = (w_sum >= LP_HIGHW) ? LP_HIGH : w_sum[PRESSURE_W-1:0];
        end else begin
            next = (w_borrow || (w_diff[PRESSURE_W-1:0] <= LP_LOW)) ? LP_LOW
                                                                    : w_diff[PRESSURE_W-1:0];
        end
    end

endmodule

// File: rtl/pressure_sequencer.sv
// Ramps chamber pressure between P_LOW and P_HIGH on request, pulsing key once per completed ramp.
// state     | meaning
// IDLE_LOW  | parked at P_LOW, accepts pressurize
// RAMP_UP   | stepping up toward P_HIGH, requests ignored
// IDLE_HIGH | parked at P_HIGH, accepts depressurize
// RAMP_DOWN | stepping down toward P_LOW, requests ignored
module pressure_sequencer
    import pressure_sequencer_pkg::*;
#(
    parameter int P_LOW  = P_LOW_DEF,
    parameter int P_HIGH = P_HIGH_DEF,
    parameter int STEP   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pressurize,
    input  logic                  depressurize,
    output logic [PRESSURE_W-1:0] pressure,
    output logic                  key,
    output logic                  busy
);

    localparam logic [PRESSURE_W-1:0] LP_LOW  = PRESSURE_W'(P_LOW);
    localparam logic [PRESSURE_W-1:0] LP_HIGH = PRESSURE_W'(P_HIGH);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [PRESSURE_W-1:0] r_pressure;
    logic [PRESSURE_W-1:0] w_pressure_nxt;
    logic                  r_key;
    logic                  w_key_nxt;
    logic [PRESSURE_W-1:0] w_step_next;
    logic                  w_dir;

    assign w_dir = (r_state == RAMP_UP);

    pressure_step #(
        .P_LOW  (P_LOW),
        .P_HIGH (P_HIGH),
        .STEP   (STEP)
    ) u_step (
        .value (r_pressure),
        .dir   (w_dir),
        .next  (w_step_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE_LOW;
            r_pressure <= LP_LOW;
            r_key      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pressure <= w_pressure_nxt;
            r_key      <= w_key_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pressure_nxt = r_pressure;
        w_key_nxt      = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                w_pressure_nxt = LP_LOW;
                if (pressurize && !depressurize) w_state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                w_pressure_nxt = w_step_next;
                if (w_step_next == LP_HIGH) begin
                    w_state_nxt = IDLE_HIGH;
                    w_key_nxt   = 1'b1;
                end
            end
            IDLE_HIGH: begin
                w_pressure_nxt = LP_HIGH;
                if (depressurize && !pressurize) w_state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                w_pressure_nxt = w_step_next;
                if (w_step_next == LP_LOW) begin
                    w_state_nxt = IDLE_LOW;
                    w_key_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = IDLE_LOW;
                w_pressure_nxt = LP_LOW;
            end
        endcase
    end

    assign pressure = r_pressure;
    assign key      = r_key;
    assign busy     = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);

endmodule

// File: doc/pressure_sequencer.md
PRESSURE_SEQUENCER -- requirements
Module: pressure_sequencer

Interface
REQ-001 The block SHALL have parameter P_LOW, default 13, meaning the low pressure limit in psi.
REQ-002 The block SHALL have parameter P_HIGH, default 16000, meaning the high pressure limit in psi.
REQ-003 The block SHALL have parameter STEP, default 1000, meaning the pressure change in psi per clock cycle while ramping.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port pressurize, input, 1 bit, meaning a request to ramp from P_LOW to P_HIGH.
REQ-007 The block SHALL have port depressurize, input, 1 bit, meaning a request to ramp from P_HIGH to P_LOW.
REQ-008 The block SHALL have port pressure, output, 14 bits, meaning the current chamber pressure in psi, unsigned.
REQ-009 The block SHALL have port key, output, 1 bit, meaning a one-cycle pulse on every limit crossing; it is the toggle input of the existing limit tracker.
REQ-010 The block SHALL have port busy, output, 1 bit, meaning high while a ramp is in progress.

Function
REQ-011 The block SHALL use four states: IDLE_LOW, RAMP_UP, IDLE_HIGH, RAMP_DOWN.
REQ-012 In IDLE_LOW, pressurize=1 and depressurize=0 at a rising edge SHALL move the state to RAMP_UP; otherwise the state SHALL hold.
REQ-013 In IDLE_HIGH, depressurize=1 and pressurize=0 at a rising edge SHALL move the state to RAMP_DOWN; otherwise the state SHALL hold.
REQ-014 Simultaneous pressurize and depressurize SHALL be ignored in every state.
REQ-015 Requests received in RAMP_UP or RAMP_DOWN SHALL be ignored: no queuing and no reversal.
REQ-016 In RAMP_UP, each rising edge SHALL set pressure to min(pressure+STEP, P_HIGH); the add is computed 15 bits wide so it cannot wrap.
REQ-017 In RAMP_DOWN, each rising edge SHALL set pressure to max(pressure-STEP, P_LOW); the subtract uses a borrow check so it cannot underflow.
REQ-018 The edge at which pressure reaches P_HIGH in RAMP_UP SHALL move the state to IDLE_HIGH and assert key for exactly one cycle.
REQ-019 The edge at which pressure reaches P_LOW in RAMP_DOWN SHALL move the state to IDLE_LOW and assert key for exactly one cycle.
REQ-020 busy SHALL equal 1 exactly when the state is RAMP_UP or RAMP_DOWN; busy is a registered-state decode.
REQ-021 key SHALL be registered, SHALL be 0 at all other times, and SHALL pulse exactly once per completed ramp; an aborted ramp produces no pulse.
REQ-022 In the idle states, pressure SHALL remain constant at P_LOW or P_HIGH respectively.

Reset
REQ-023 reset=1 at a rising edge SHALL force the state to IDLE_LOW, pressure to P_LOW, key to 0 and busy to 0, and SHALL take priority over all requests.
REQ-024 reset asserted mid-ramp SHALL abort the ramp with no key pulse, and pressure SHALL equal P_LOW on the next cycle.
REQ-025 After reset, the pressure state SHALL agree with the limit tracker's WITHIN state, so that the tracker and this block stay in phase.

Structure
REQ-026 A shared package SHALL hold the state encoding (2-bit: IDLE_LOW=00, RAMP_UP=01, IDLE_HIGH=10, RAMP_DOWN=11), the P_LOW and P_HIGH defaults, and the pressure width constant of 14.
REQ-027 One sub-module, pressure_step, SHALL be instantiated: a combinational saturating add/subtract of STEP clamped to [P_LOW, P_HIGH], with inputs value and dir and output next.
REQ-028 The state register SHALL use the team's synchronous-reset register style; no latches and no combinational path from inputs to key.

Verification
REQ-029 The bench SHALL cover: reset, then idle for 5 cycles -> pressure=13, key=0, busy=0 throughout.
REQ-030 The bench SHALL cover: pressurize for 1 cycle from IDLE_LOW -> busy for 16 cycles, pressure sequence 1013, 2013, ..., 15013, 16000, then a single key pulse coincident with the first IDLE_HIGH cycle.
REQ-031 The bench SHALL cover: depressurize from IDLE_HIGH -> 16 cycles of 15000, 14000, ..., 1000, 13, then one key pulse and return to IDLE_LOW.
REQ-032 The bench SHALL cover: depressurize while in IDLE_LOW, pressurize held high throughout RAMP_UP, and both requests high in IDLE_HIGH -> no state change beyond the legal ramp and exactly one key pulse in total.
REQ-033 The bench SHALL cover: reset asserted at ramp cycle 7 (pressure=7013) -> the next cycle shows pressure=13, state IDLE_LOW and no key pulse.
REQ-034 The bench SHALL cover: two full up/down round trips with this block's key feeding the limit tracker -> the tracker's limit output is 1 exactly while the state is IDLE_HIGH or RAMP_DOWN, one cycle after each key pulse.
